// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity-mode constants and the
// parity check used by the receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam logic UART_PARITY_EVEN = 1'b0;
    localparam logic UART_PARITY_ODD  = 1'b1;

    // Data is zero-extended to 8 bits, which does not change its XOR reduction.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       par_bit,
                                             input logic       odd_mode);
        return ((^data) ^ par_bit) != odd_mode;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to RESET_VAL
// so an idle-high line reads idle straight out of reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Double-register the async input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: oversamples the synchronized rxd line at bit centres and
// presents each complete frame as a byte behind a valid/ready handshake.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD_MODE = (PARITY_ODD != 0) ? UART_PARITY_ODD : UART_PARITY_EVEN;

    logic                 rxs_s;
    rx_state_t            state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [BIT_W-1:0]     bit_r, bit_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_bit_r, par_bit_s;
    logic                 good_stop_s, bad_stop_s;
    logic                 par_err_s;
    logic                 load_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs_s)
    );

    // FSM state and bit-timing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_r     <= '0;
            shift_r   <= '0;
            par_bit_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_r     <= bit_s;
            shift_r   <= shift_s;
            par_bit_r <= par_bit_s;
        end
    end

    // Next-state, counter and sampling decisions, all taken from the synchronized line
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_s       = bit_r;
        shift_s     = shift_r;
        par_bit_s   = par_bit_r;
        good_stop_s = 1'b0;
        bad_stop_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_s = ST_START;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_s = '0;
                    bit_s = '0;
                    // A start bit that is gone by mid-bit was a glitch
                    if (!rxs_s) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    shift_s = {rxs_s, shift_r[DATA_BITS-1:1]};
                    bit_s   = bit_r + BIT_W'(1);
                    if (bit_r == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_STOP;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s     = '0;
                    par_bit_s = rxs_s;
                    state_s   = ST_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (rxs_s) begin
                        good_stop_s = 1'b1;
                        state_s     = ST_IDLE;
                    end else begin
                        bad_stop_s = 1'b1;
                        state_s    = ST_BREAK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                // A held-low line must not be taken as a fresh start bit
                if (rxs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                bit_s   = '0;
            end
        endcase
    end

    // Parity verdict and delivery decision for the frame finishing this cycle
    always_comb begin
        par_err_s = 1'b0;
        load_s    = 1'b0;
        if (PARITY_EN != 0) begin
            par_err_s = parity_mismatch(8'(shift_r), par_bit_r, ODD_MODE);
        end else begin
            par_err_s = 1'b0;
        end
        if (good_stop_s && (!rx_valid || rx_ready)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Output register: delivered byte, handshake and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= bad_stop_s;
            overrun   <= good_stop_s & rx_valid & ~rx_ready;
            busy      <= (state_s != ST_IDLE);
            if (load_s) begin
                rx_data    <= shift_r;
                parity_err <= par_err_s;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: an 8N1 instance and an 8E1 instance share
// clock, reset and rx_ready; each has its own serial line.
module tb_uart_rx_deser;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rxd_p = 1'b1;
    logic       rx_ready = 1'b1;

    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       parity_err, parity_err_p;
    logic       frame_err, frame_err_p;
    logic       overrun, overrun_p;
    logic       busy, busy_p;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int         v_rise = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, rise_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_v = 1'b0;
    int         pv_rise = 0, p_flag_cnt = 0;
    logic [7:0] p_last_data = 8'h00;
    logic       p_last_perr = 1'b0;
    logic       prev_pv = 1'b0;

    always #5 clk = ~clk;

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .rxd(rxd_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_ready(rx_ready), .parity_err(parity_err_p), .frame_err(frame_err_p),
        .overrun(overrun_p), .busy(busy_p)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid && !prev_v) begin
            v_rise    = v_rise + 1;
            last_data = rx_data;
            rise_cyc  = cyc;
        end
        prev_v = rx_valid;
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun) ov_cnt = ov_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (rx_valid_p && !prev_pv) begin
            pv_rise     = pv_rise + 1;
            p_last_data = rx_data_p;
            p_last_perr = parity_err_p;
        end
        prev_pv = rx_valid_p;
        if (frame_err_p || overrun_p) p_flag_cnt = p_flag_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_bit(input int which, input logic val);
        if (which == 0) rxd = val;
        else rxd_p = val;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, data LSB first, optional parity bit, stop bit; caller is at a negedge
    task automatic send(input int which, input logic [7:0] data, input logic par_en,
                        input logic par_bit, input logic stop_bit);
        hold_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(which, data[i]);
        if (par_en) hold_bit(which, par_bit);
        hold_bit(which, stop_bit);
        if (which == 0) rxd = 1'b1;
        else rxd_p = 1'b1;
    endtask

    int base_v, base_fe, base_ov, base_busy, base_pv, t0;

    initial begin
        idle(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(4);

        // 1: 0xA5 8N1 with rx_ready high
        base_v = v_rise; base_fe = fe_cnt; base_ov = ov_cnt;
        t0 = cyc;
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("t1_count", v_rise - base_v, 1);
        check("t1_data", last_data, 8'hA5);
        check("t1_latency", (rise_cyc - t0 >= 153) && (rise_cyc - t0 <= 155), 1);
        check("t1_valid_drop", rx_valid, 0);
        check("t1_flags", (fe_cnt - base_fe) + (ov_cnt - base_ov), 0);

        // 2: 4-cycle low glitch
        base_v = v_rise; base_fe = fe_cnt; base_busy = busy_cnt;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        check("t2_busy_short", ((busy_cnt - base_busy) > 0) && ((busy_cnt - base_busy) < 10), 1);
        check("t2_no_valid", v_rise - base_v, 0);
        check("t2_no_ferr", fe_cnt - base_fe, 0);

        // 3: 0x3C with stop bit low, line held low, then 0x81
        base_v = v_rise; base_fe = fe_cnt;
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        rxd = 1'b0;
        idle(40);
        check("t3_ferr", fe_cnt - base_fe, 1);
        check("t3_no_valid", v_rise - base_v, 0);
        check("t3_break_busy", busy, 1);
        rxd = 1'b1;
        idle(5);
        check("t3_break_exit", busy, 0);
        idle(16);
        send(0, 8'h81, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("t3_next_count", v_rise - base_v, 1);
        check("t3_next_data", last_data, 8'h81);

        // 4: overrun with rx_ready low
        rx_ready = 1'b0;
        base_v = v_rise; base_ov = ov_cnt;
        send(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("t4_count", v_rise - base_v, 1);
        check("t4_held_valid", rx_valid, 1);
        check("t4_kept_data", rx_data, 8'h11);
        check("t4_overrun", ov_cnt - base_ov, 1);
        rx_ready = 1'b1;
        idle(2);
        check("t4_accept_drop", rx_valid, 0);

        // 5: even parity instance, 0x07 has odd weight
        base_pv = pv_rise;
        send(1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle(30);
        check("t5_count_a", pv_rise - base_pv, 1);
        check("t5_data_a", p_last_data, 8'h07);
        check("t5_perr_a", p_last_perr, 1);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(30);
        check("t5_count_b", pv_rise - base_pv, 2);
        check("t5_perr_b", p_last_perr, 0);
        check("t5_no_flags", p_flag_cnt, 0);

        // 6: reset in the middle of 0xFF, then 0x5A
        base_v = v_rise;
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        hold_bit(0, 1'b1);
        hold_bit(0, 1'b1);
        rst = 1'b1;
        idle(2);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pulses", {frame_err, overrun, parity_err}, 0);
        rst = 1'b0;
        idle(100);
        check("t6_abandoned", v_rise - base_v, 0);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("t6_count", v_rise - base_v, 1);
        check("t6_data", last_data, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
